// File: rtl/csa_pipelined_final_adder.sv
// Final carry-propagate adder for the multiplier reduction tree: resolves the
// sum/carry vectors SEG bits per stage through a valid/ready pipeline.
module csa_pipelined_final_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec_in,
    input  logic [WIDTH-1:0] carry_vec_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result_out,
    output logic             busy
);
    localparam int STAGES = WIDTH / SEG;

    // Each stage carries the bits resolved so far plus the operands still to add.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t         stg_q [STAGES];
    stage_t         stg_d [STAGES];
    stage_t         src_c;
    logic [SEG:0]   seg_c;
    logic           en;

    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic           c;
        logic [SEG-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // The whole pipeline advances together; only the last stage can hold it.
    always_comb begin
        // NOTE: every combinational variable gets a default first so no path infers a latch.
        en    = out_ready | ~stg_q[STAGES-1].valid;
        src_c = '0;
        seg_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_c       = '0;
                src_c.valid = in_valid & en;
                src_c.a     = sum_vec_in;
                src_c.b     = carry_vec_in;
            end else begin
                src_c = stg_q[k-1];
            end
            seg_c                   = seg_add(src_c.a[k*SEG +: SEG], src_c.b[k*SEG +: SEG], src_c.carry);
            stg_d[k]                = src_c;
            stg_d[k].res[k*SEG +: SEG] = seg_c[SEG-1:0];
            stg_d[k].carry          = seg_c[SEG];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: pipeline registers are control-bearing state, so every element is reset.
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            stg_q <= stg_d;
        end
    end

    always_comb begin
        in_ready   = en;
        out_valid  = stg_q[STAGES-1].valid;
        result_out = {stg_q[STAGES-1].carry, stg_q[STAGES-1].res};
        busy       = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | stg_q[k].valid;
        end
    end

endmodule

// File: tb/tb_csa_pipelined_final_adder.sv
// Directed self-checking bench for csa_pipelined_final_adder (WIDTH=16, SEG=4).
module tb_csa_pipelined_final_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_vec_in;
    logic [15:0] carry_vec_in;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] result_out;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    csa_pipelined_final_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sum_vec_in   (sum_vec_in),
        .carry_vec_in (carry_vec_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_out   (result_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: accept, confirm no early result, exact 4-cycle latency, single pulse.
    task automatic run_single(input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] exp, input string tag);
        sum_vec_in   = a;
        carry_vec_in = b;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_early"}, 32'(out_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'h1);
        chk({tag, "_res"}, 32'(result_out), exp);
        tick();
        chk({tag, "_pulse"}, 32'(out_valid), 32'h0);
    endtask

    logic [15:0] bp_a   [6];
    logic [15:0] bp_b   [6];
    logic [31:0] bp_exp [6];
    logic [31:0] st_exp [8];

    initial begin
        int p;
        bp_a   = '{16'hFFF0, 16'h8001, 16'h1234, 16'h7FFF, 16'hABCD, 16'h0000};
        bp_b   = '{16'h0010, 16'h8000, 16'h4321, 16'h8001, 16'h5432, 16'h0000};
        bp_exp = '{32'h10000, 32'h10001, 32'h05555, 32'h10000, 32'h0FFFF, 32'h00000};
        st_exp = '{32'h0101, 32'h1213, 32'h2325, 32'h3437, 32'h4549, 32'h565B, 32'h676D, 32'h787F};

        // Reset asserted before any clock edge: outputs must already be cleared.
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        sum_vec_in   = '0;
        carry_vec_in = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", 32'(result_out), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        run_single(16'h00FF, 16'h0001, 32'h00100, "single");
        run_single(16'hFFFF, 16'h0001, 32'h10000, "ffff_p1");
        run_single(16'hFFFF, 16'hFFFF, 32'h1FFFE, "ffff_pffff");
        run_single(16'h0F0F, 16'h00F1, 32'h01000, "seg_ripple");

        // Streaming: eight back-to-back operands, results every cycle in order.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                in_valid     = 1'b1;
                sum_vec_in   = 16'(c * 16'h1111);
                carry_vec_in = 16'(16'h0101 + c);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 2) chk("stream_early", 32'(out_valid), 32'h0);
            if (c >= 3 && c < 11) begin
                chk($sformatf("stream_valid_%0d", c - 3), 32'(out_valid), 32'h1);
                chk($sformatf("stream_res_%0d", c - 3), 32'(result_out), st_exp[c-3]);
            end
            if (c == 11) chk("stream_end", 32'(out_valid), 32'h0);
        end

        // Backpressure: out_ready low for cycles 4..6 while inputs keep streaming.
        p = 0;
        for (int c = 0; c < 13; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            if (p < 6) begin
                in_valid     = 1'b1;
                sum_vec_in   = bp_a[p];
                carry_vec_in = bp_b[p];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'h0);
            if (in_valid && out_ready) p++;
            tick();
            if (c >= 3 && c <= 6) begin
                chk($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 32'h1);
                chk($sformatf("bp_hold_res_%0d", c), 32'(result_out), bp_exp[0]);
            end
            if (c >= 7 && c <= 11) begin
                chk($sformatf("bp_valid_%0d", c - 6), 32'(out_valid), 32'h1);
                chk($sformatf("bp_res_%0d", c - 6), 32'(result_out), bp_exp[c-6]);
            end
            if (c == 12) chk("bp_drain", 32'(out_valid), 32'h0);
        end
        out_ready = 1'b1;

        // Reset mid-flight: three operations in the pipe, reset asserted mid-cycle.
        for (int i = 0; i < 3; i++) begin
            in_valid     = 1'b1;
            sum_vec_in   = 16'h1000 + 16'(i);
            carry_vec_in = 16'h0001;
            tick();
        end
        in_valid = 1'b0;
        chk("flight_busy", 32'(busy), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_result", 32'(result_out), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst_quiet_%0d", i), 32'(out_valid), 32'h0);
        end
        run_single(16'h1234, 16'h0001, 32'h01235, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
